// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer.
// Covers FSM states, opcodes, datapath mux selects and the per-cycle control bundle.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_FUNCT = 3'd2,
    ALU_AND = 3'd3, ALU_OR = 3'd4, ALU_SLT = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_REG = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {A_PC = 2'd0, A_REG = 2'd1, A_SHAMT = 2'd2} alu_src_a_t;

  typedef enum logic [2:0] {
    B_REG = 3'd0, B_ONE = 3'd1, B_SIMM = 3'd2, B_ZIMM = 3'd3, B_UPPER = 3'd4
  } alu_src_b_t;

  typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2} reg_dst_t;
  typedef enum logic [1:0] {M2R_ALU = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2} mem_to_reg_t;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_ILLEGAL = 2'd1, ERR_TIMEOUT = 2'd2} err_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_JR, CLS_MEM, CLS_BRANCH, CLS_JUMP, CLS_IMM, CLS_ILLEGAL
  } instr_cls_t;

  typedef struct packed {
    instr_cls_t cls;
    logic       is_store;
    logic       is_bne;
    logic       is_link;
    alu_src_a_t src_a;
    alu_src_b_t src_b;
    alu_op_t    op;
  } dec_t;

  typedef struct packed {
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic        reg_we;
    logic        dmem_rd;
    logic        dmem_wr;
    logic        retire;
    pc_src_t     pc_src;
    reg_dst_t    reg_dst;
    mem_to_reg_t m2r;
    alu_src_a_t  src_a;
    alu_src_b_t  src_b;
    alu_op_t     op;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                PC_ALU, DST_RT, M2R_ALU, A_PC, B_REG, ALU_ADD};

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class
// plus the ALU operand selects and operation used by the execute-type states.
module mips_mc_decode
  import mips_mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec.cls      = CLS_ILLEGAL;
    dec.is_store = 1'b0;
    dec.is_bne   = 1'b0;
    dec.is_link  = 1'b0;
    dec.src_a    = A_REG;
    dec.src_b    = B_REG;
    dec.op       = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        dec.cls   = (funct == FN_JR) ? CLS_JR : CLS_R;
        // Shifts take the shift amount from the instruction, not from rs.
        dec.src_a = (funct == FN_SLL || funct == FN_SRL) ? A_SHAMT : A_REG;
        dec.op    = ALU_FUNCT;
      end
      OP_LW, OP_SW: begin
        dec.cls      = CLS_MEM;
        dec.is_store = (opcode == OP_SW);
        dec.src_b    = B_SIMM;
      end
      OP_BEQ, OP_BNE: begin
        dec.cls    = CLS_BRANCH;
        dec.is_bne = (opcode == OP_BNE);
        dec.op     = ALU_SUB;
      end
      OP_J, OP_JAL: begin
        dec.cls     = CLS_JUMP;
        dec.is_link = (opcode == OP_JAL);
      end
      OP_ADDI: begin dec.cls = CLS_IMM; dec.src_b = B_SIMM;  dec.op = ALU_ADD; end
      OP_SLTI: begin dec.cls = CLS_IMM; dec.src_b = B_SIMM;  dec.op = ALU_SLT; end
      OP_ANDI: begin dec.cls = CLS_IMM; dec.src_b = B_ZIMM;  dec.op = ALU_AND; end
      OP_ORI:  begin dec.cls = CLS_IMM; dec.src_b = B_ZIMM;  dec.op = ALU_OR;  end
      OP_LUI:  begin dec.cls = CLS_IMM; dec.src_b = B_UPPER; dec.op = ALU_ADD; end
      default: dec.cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: state register, dispatch, memory-wait
// watchdog, retire counter and sticky error; controls are decoded from state.
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [2:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             retire,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       dbg_state
);

  localparam int WC_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam int LIM_M1 = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(LIM_M1);

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt;
  logic [CNT_W-1:0] cnt_q;
  err_t             err_q;
  dec_t             dec;
  ctl_t             ctl, ctl_o;
  logic             wait_last, wait_inc, timeout, illegal;

  mips_mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  assign wait_last = (WAIT_LIMIT != 0) && (wait_cnt == WC_LAST);

  // Handshake: imem_req / dmem_rd / dmem_wr stay high every cycle until the
  // matching ready is seen high in the same cycle; the transfer completes on
  // that cycle and the strobe drops on the next. A timeout cycle drives nothing.
  always_comb begin
    ctl      = CTL_IDLE;
    state_d  = state_q;
    wait_inc = 1'b0;
    timeout  = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!imem_ready && wait_last) begin
          timeout = 1'b1;
          state_d = S_HALT;
        end else begin
          ctl.imem_req = 1'b1;
          ctl.src_b    = B_ONE;
          ctl.ir_we    = imem_ready;
          ctl.pc_we    = imem_ready;
          wait_inc     = !imem_ready;
          if (imem_ready) state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut while the class is resolved.
        ctl.src_b = B_SIMM;
        case (dec.cls)
          CLS_R:      state_d = S_EXEC_R;
          CLS_JR:     state_d = S_JR;
          CLS_MEM:    state_d = S_MEM_ADDR;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JUMP:   state_d = S_JUMP;
          CLS_IMM:    state_d = S_EXEC_I;
          default: begin
            illegal = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_MEM_ADDR: begin
        ctl.src_a = dec.src_a;
        ctl.src_b = dec.src_b;
        ctl.op    = dec.op;
        if (state_q == S_EXEC_R)      state_d = S_WB_R;
        else if (state_q == S_EXEC_I) state_d = S_WB_I;
        else                          state_d = dec.is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_WB_R, S_WB_I, S_WB_MEM: begin
        ctl.reg_we = 1'b1;
        ctl.retire = 1'b1;
        if (state_q == S_WB_R)   ctl.reg_dst = DST_RD;
        if (state_q == S_WB_MEM) ctl.m2r = M2R_MDR;
        state_d = S_FETCH;
      end
      S_MEM_RD, S_MEM_WR: begin
        if (!dmem_ready && wait_last) begin
          timeout = 1'b1;
          state_d = S_HALT;
        end else begin
          ctl.dmem_rd = (state_q == S_MEM_RD);
          ctl.dmem_wr = (state_q == S_MEM_WR);
          ctl.retire  = (state_q == S_MEM_WR) && dmem_ready;
          wait_inc    = !dmem_ready;
          if (dmem_ready) state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end
      end
      S_BRANCH: begin
        ctl.src_a  = dec.src_a;
        ctl.src_b  = dec.src_b;
        ctl.op     = dec.op;
        ctl.pc_src = PC_ALUOUT;
        ctl.pc_we  = dec.is_bne ? !zero : zero;
        ctl.retire = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_we  = 1'b1;
        ctl.pc_src = PC_JUMP;
        ctl.retire = 1'b1;
        if (dec.is_link) begin
          ctl.reg_we  = 1'b1;
          ctl.reg_dst = DST_R31;
          ctl.m2r     = M2R_PC;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        ctl.pc_we  = 1'b1;
        ctl.pc_src = PC_REG;
        ctl.retire = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      cnt_q    <= '0;
      err_q    <= ERR_NONE;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) wait_cnt <= '0;
      else if (wait_inc)      wait_cnt <= wait_cnt + 1'b1;
      if (ctl.retire) cnt_q <= cnt_q + 1'b1;
      if (illegal)      err_q <= ERR_ILLEGAL;
      else if (timeout) err_q <= ERR_TIMEOUT;
    end
  end

  assign ctl_o       = RST ? ctl : CTL_IDLE;
  assign imem_req    = ctl_o.imem_req;
  assign ir_we       = ctl_o.ir_we;
  assign pc_we       = ctl_o.pc_we;
  assign pc_src      = ctl_o.pc_src;
  assign alu_src_a   = ctl_o.src_a;
  assign alu_src_b   = ctl_o.src_b;
  assign alu_op      = ctl_o.op;
  assign reg_we      = ctl_o.reg_we;
  assign reg_dst     = ctl_o.reg_dst;
  assign mem_to_reg  = ctl_o.m2r;
  assign dmem_rd     = ctl_o.dmem_rd;
  assign dmem_wr     = ctl_o.dmem_wr;
  assign retire      = ctl_o.retire;
  assign halted      = RST && (state_q == S_HALT);
  assign err         = RST ? err_q : ERR_NONE;
  assign instr_count = RST ? cnt_q : '0;
  assign dbg_state   = RST ? state_q : S_FETCH;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: an instruction-level timeline model builds the
// expected per-cycle control vector, and each cycle is compared at the falling edge.
module tb_mips_multicycle_ctrl;

  localparam int WAIT_LIMIT = 16;
  localparam int CNT_W      = 4;
  localparam int W          = 24;

  logic CLK = 1'b0;
  logic RST;
  logic [5:0] opcode, funct;
  logic zero, imem_ready, dmem_ready;
  logic imem_req, ir_we, pc_we, reg_we, dmem_rd, dmem_wr, retire, halted;
  logic [1:0] pc_src, alu_src_a, reg_dst, mem_to_reg, err;
  logic [2:0] alu_src_b, alu_op;
  logic [CNT_W-1:0] instr_count;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int model_count = 0;
  logic [W-1:0] exp_q[$];
  logic [1:0]   stim_q[$];
  logic [5:0] cur_op, cur_fn;
  logic       cur_z;
  logic [W-1:0] obs;

  logic [5:0] ops [12] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                           6'h03, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
  logic [5:0] fns [8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08};

  always #5 CLK = ~CLK;

  mips_multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .retire(retire), .halted(halted),
    .err(err), .instr_count(instr_count), .dbg_state(dbg_state)
  );

  assign obs = {halted, err, imem_req, ir_we, pc_we, reg_we, dmem_rd, dmem_wr, retire,
                pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};

  // st = {imem_req, ir_we, pc_we, reg_we, dmem_rd, dmem_wr, retire}
  function automatic logic [W-1:0] pk(input logic [6:0] st, input logic [1:0] ps,
                                      input logic [1:0] rd, input logic [1:0] m2r,
                                      input logic [1:0] a, input logic [2:0] b,
                                      input logic [2:0] op);
    return {3'b000, st, ps, rd, m2r, a, b, op};
  endfunction

  function automatic logic rb();
    return $urandom_range(0, 1) != 0;
  endfunction

  task automatic push(input logic [W-1:0] e, input logic im, input logic dm);
    exp_q.push_back(e);
    stim_q.push_back({im, dm});
  endtask

  task automatic model_halt(input logic [1:0] e, input int n);
    for (int i = 0; i < n; i++) push({1'b1, e, 21'd0}, rb(), rb());
  endtask

  // d cycles of ready low then one ready cycle, or a timeout when d reaches the limit.
  task automatic model_wait(input logic [W-1:0] wait_e, input logic [W-1:0] done_e,
                            input int d, input logic is_imem, output logic to);
    to = (d >= WAIT_LIMIT);
    for (int i = 0; i < (to ? WAIT_LIMIT - 1 : d); i++)
      push(wait_e, is_imem ? 1'b0 : rb(), is_imem ? rb() : 1'b0);
    if (to) begin
      push('0, is_imem ? 1'b0 : rb(), is_imem ? rb() : 1'b0);
      model_halt(2'd2, 4);
    end else begin
      push(done_e, is_imem ? 1'b1 : rb(), is_imem ? rb() : 1'b1);
    end
  endtask

  task automatic model_imm(input logic [2:0] b, input logic [2:0] op);
    push(pk(7'b0000000, 2'd0, 2'd0, 2'd0, 2'd1, b, op), rb(), rb());
    push(pk(7'b0001001, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), rb(), rb());
  endtask

  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int di, input int dd, output logic halt);
    logic to;
    halt = 1'b0;
    cur_op = op; cur_fn = fn; cur_z = z;
    model_wait(pk(7'b1000000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd1, 3'd0),
               pk(7'b1110000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd1, 3'd0), di, 1'b1, to);
    if (to) begin halt = 1'b1; return; end
    push(pk(7'b0000000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd2, 3'd0), rb(), rb());
    case (op)
      6'h00: begin
        if (fn == 6'h08) begin
          push(pk(7'b0010001, 2'd3, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), rb(), rb());
        end else begin
          push(pk(7'b0000000, 2'd0, 2'd0, 2'd0, (fn == 6'h00 || fn == 6'h02) ? 2'd2 : 2'd1,
                  3'd0, 3'd2), rb(), rb());
          push(pk(7'b0001001, 2'd0, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0), rb(), rb());
        end
      end
      6'h23, 6'h2B: begin
        push(pk(7'b0000000, 2'd0, 2'd0, 2'd0, 2'd1, 3'd2, 3'd0), rb(), rb());
        if (op == 6'h23) begin
          model_wait(pk(7'b0000100, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0),
                     pk(7'b0000100, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), dd, 1'b0, to);
          if (!to) push(pk(7'b0001001, 2'd0, 2'd0, 2'd1, 2'd0, 3'd0, 3'd0), rb(), rb());
        end else begin
          model_wait(pk(7'b0000010, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0),
                     pk(7'b0000011, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), dd, 1'b0, to);
        end
        if (to) begin halt = 1'b1; return; end
      end
      6'h04, 6'h05:
        push(pk({2'b00, (op == 6'h04) ? z : !z, 4'b0001}, 2'd1, 2'd0, 2'd0, 2'd1, 3'd0, 3'd1),
             rb(), rb());
      6'h02: push(pk(7'b0010001, 2'd2, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0), rb(), rb());
      6'h03: push(pk(7'b0011001, 2'd2, 2'd2, 2'd2, 2'd0, 3'd0, 3'd0), rb(), rb());
      6'h08: model_imm(3'd2, 3'd0);
      6'h0A: model_imm(3'd2, 3'd5);
      6'h0C: model_imm(3'd3, 3'd3);
      6'h0D: model_imm(3'd3, 3'd4);
      6'h0F: model_imm(3'd4, 3'd0);
      default: begin
        model_halt(2'd1, 4);
        halt = 1'b1;
        return;
      end
    endcase
    model_count = (model_count + 1) % (1 << CNT_W);
  endtask

  task automatic run_queue(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] e;
      logic [1:0]   s;
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      @(negedge CLK);
      RST = 1'b1; opcode = cur_op; funct = cur_fn; zero = cur_z;
      imem_ready = s[1]; dmem_ready = s[0];
      #1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h, expected %h", name, i + 1, obs, e);
      end
    end
    exp_q.delete();
    stim_q.delete();
  endtask

  task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int di, input int dd);
    logic h;
    model_instr(op, fn, z, di, dd, h);
    run_queue(name, exp_q.size());
    @(posedge CLK); #1;
    checks++;
    if (instr_count !== model_count[CNT_W-1:0]) begin
      errors++;
      $display("FAIL %s count: got %0d, expected %0d", name, instr_count, model_count);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RST = 1'b0; imem_ready = rb(); dmem_ready = rb(); zero = rb();
      opcode = 6'($urandom); funct = 6'($urandom);
      #1;
      checks++;
      if (obs !== '0 || instr_count !== '0) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h count %0d, expected all zero", i, obs, instr_count);
      end
    end
    model_count = 0;
  endtask

  task automatic test_reset();
    do_reset(3);
    do_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
  endtask

  task automatic test_mem();
    do_instr("lw_wait3", 6'h23, 6'h00, 1'b0, 0, 3);
    do_instr("sw", 6'h2B, 6'h00, 1'b0, 0, 0);
    do_instr("sw_wait2", 6'h2B, 6'h00, 1'b1, 2, 2);
  endtask

  task automatic test_branch();
    do_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0);
    do_instr("bne_not_taken", 6'h05, 6'h00, 1'b1, 0, 0);
    do_instr("beq_not_taken", 6'h04, 6'h00, 1'b0, 0, 0);
    do_instr("bne_taken", 6'h05, 6'h00, 1'b0, 0, 0);
  endtask

  task automatic test_jumps();
    do_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0);
    do_instr("j", 6'h02, 6'h00, 1'b0, 0, 0);
    do_instr("jr", 6'h00, 6'h08, 1'b0, 0, 0);
    do_instr("sll", 6'h00, 6'h00, 1'b0, 1, 0);
  endtask

  task automatic test_imm();
    for (int i = 7; i < 12; i++) do_instr("imm", ops[i], 6'h00, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      do_instr("random", ops[$urandom_range(0, 11)], fns[$urandom_range(0, 7)], rb(),
               $urandom_range(0, 4), $urandom_range(0, 4));
  endtask

  task automatic test_mid_reset();
    logic h;
    model_instr(6'h23, 6'h00, 1'b0, 0, 6, h);
    run_queue("lw_abandon", 5);
    do_reset(2);
    do_instr("add_after_reset", 6'h00, 6'h22, 1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    do_reset(2);
    do_instr("imem_timeout", 6'h00, 6'h20, 1'b0, 16, 0);
    do_reset(2);
    do_instr("imem_ready_at_limit", 6'h00, 6'h20, 1'b0, 15, 0);
    do_reset(2);
    do_instr("dmem_timeout", 6'h23, 6'h00, 1'b0, 0, 16);
    do_reset(2);
    do_instr("dmem_ready_at_limit", 6'h2B, 6'h00, 1'b0, 0, 15);
  endtask

  task automatic test_illegal();
    do_reset(2);
    do_instr("illegal_3f", 6'h3F, 6'h00, 1'b0, 0, 0);
    do_reset(2);
    do_instr("illegal_01", 6'h01, 6'h00, 1'b0, 1, 0);
    do_reset(2);
    do_instr("add_after_halt", 6'h00, 6'h24, 1'b0, 0, 0);
  endtask

  initial begin
    RST = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    cur_op = '0; cur_fn = '0; cur_z = 1'b0;
    test_reset();
    test_mem();
    test_branch();
    test_jumps();
    test_imm();
    test_back_to_back();
    test_mid_reset();
    test_timeout();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
